// File: rtl/spi_multi_encoder_reader.sv
// N-channel x4 quadrature counter with a mode-0 SPI slave readout.
// Counts are snapshotted at chip-select assertion so multi-byte reads are coherent.
module spi_multi_encoder_reader #(
   parameter int unsigned NUM_ENC     = 4,
   parameter int unsigned COUNT_W     = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_ENC-1:0] encA,
   input  logic [NUM_ENC-1:0] encB,
   input  logic               cs_n,
   input  logic               sck,
   input  logic               mosi,
   output logic               miso,
   output logic               miso_oe,
   output logic [NUM_ENC-1:0] errFlags
);

   localparam int unsigned NBYTES   = COUNT_W / 8;
   localparam int unsigned ERR_ADDR = NUM_ENC * NBYTES;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_NULL} spi_state_t;

   logic [SYNC_STAGES-1:0][NUM_ENC-1:0] a_sync, b_sync;
   logic [SYNC_STAGES-1:0]              cs_sync, sck_sync, mosi_sync;
   logic [NUM_ENC-1:0]                  a_s, b_s;
   logic                                cs_s, sck_s, mosi_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync    <= '0;
         b_sync    <= '0;
         cs_sync   <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
      end else begin
         a_sync    <= {a_sync[SYNC_STAGES-2:0], encA};
         b_sync    <= {b_sync[SYNC_STAGES-2:0], encB};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      end
   end

   assign a_s    = a_sync[SYNC_STAGES-1];
   assign b_s    = b_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Quadrature decode: map Gray {A,B} to a 0..3 position, the modular
   // difference gives +1, -1, hold, or an illegal double change.
   logic [NUM_ENC-1:0] a_prev, b_prev;
   logic [NUM_ENC-1:0] step_up, step_dn, step_bad;
   logic [1:0]         pos_new, pos_old, pos_diff;

   always_comb begin
      step_up  = '0;
      step_dn  = '0;
      step_bad = '0;
      pos_new  = '0;
      pos_old  = '0;
      pos_diff = '0;
      for (int unsigned c = 0; c < NUM_ENC; c++) begin
         pos_new     = {a_s[c], a_s[c] ^ b_s[c]};
         pos_old     = {a_prev[c], a_prev[c] ^ b_prev[c]};
         pos_diff    = pos_new - pos_old;
         step_up[c]  = (pos_diff == 2'd1);
         step_dn[c]  = (pos_diff == 2'd3);
         step_bad[c] = (pos_diff == 2'd2);
      end
   end

   logic [COUNT_W-1:0] count [NUM_ENC];
   logic               clr_pulse;
   logic [6:0]         clr_ch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_prev   <= '0;
         b_prev   <= '0;
         errFlags <= '0;
         for (int unsigned c = 0; c < NUM_ENC; c++) count[c] <= '0;
      end else begin
         a_prev <= a_s;
         b_prev <= b_s;
         for (int unsigned c = 0; c < NUM_ENC; c++) begin
            if (clr_pulse && clr_ch == 7'(c)) begin
               count[c]    <= '0;
               errFlags[c] <= 1'b0;
            end else begin
               if (step_up[c])
                  count[c] <= count[c] + COUNT_W'(1);
               else if (step_dn[c])
                  count[c] <= count[c] - COUNT_W'(1);
               if (step_bad[c])
                  errFlags[c] <= 1'b1;
            end
         end
      end
   end

   spi_state_t         state;
   logic               cs_prev, sck_prev;
   logic               cs_fall, sck_rise, sck_fall;
   logic [2:0]         bit_cnt;
   logic [6:0]         rx;
   logic [7:0]         rx_byte;
   logic [7:0]         tx;
   logic [6:0]         ptr;
   logic [6:0]         rd_addr;
   logic [7:0]         rd_byte;
   logic [COUNT_W-1:0] shadow [NUM_ENC];
   logic [NUM_ENC-1:0] shadow_err;

   assign cs_fall  = cs_prev & ~cs_s;
   assign sck_rise = ~sck_prev & sck_s & ~cs_s;
   assign sck_fall = sck_prev & ~sck_s & ~cs_s;
   assign rx_byte  = {rx, mosi_s};

   // During the command byte the address comes straight from the byte being
   // completed, so the first data byte is ready on the same clk.
   always_comb begin
      rd_addr = (state == ST_CMD) ? rx_byte[6:0] : ptr;
      rd_byte = '0;
      for (int unsigned c = 0; c < NUM_ENC; c++)
         for (int unsigned j = 0; j < NBYTES; j++)
            if (rd_addr == 7'(c * NBYTES + j))
               rd_byte = shadow[c][(NBYTES-1-j)*8 +: 8];
      if (rd_addr == 7'(ERR_ADDR))
         rd_byte = 8'(shadow_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cs_prev    <= 1'b1;
         sck_prev   <= 1'b0;
         bit_cnt    <= '0;
         rx         <= '0;
         tx         <= '0;
         ptr        <= '0;
         clr_pulse  <= 1'b0;
         clr_ch     <= '0;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         shadow_err <= '0;
         for (int unsigned c = 0; c < NUM_ENC; c++) shadow[c] <= '0;
      end else begin
         cs_prev   <= cs_s;
         sck_prev  <= sck_s;
         clr_pulse <= 1'b0;
         miso_oe   <= ~cs_s;
         miso      <= ~cs_s & tx[7];
         if (cs_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx      <= '0;
         end else if (cs_fall) begin
            state      <= ST_CMD;
            bit_cnt    <= '0;
            tx         <= '0;
            shadow     <= count;
            shadow_err <= errFlags;
         end else if (state != ST_IDLE) begin
            if (sck_rise) begin
               rx      <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  case (state)
                     ST_CMD: begin
                        if (rx_byte[7]) begin
                           state     <= ST_NULL;
                           tx        <= '0;
                           clr_ch    <= rx_byte[6:0];
                           clr_pulse <= (32'(rx_byte[6:0]) < NUM_ENC);
                        end else begin
                           state <= ST_DATA;
                           tx    <= rd_byte;
                           ptr   <= rx_byte[6:0] + 7'd1;
                        end
                     end
                     ST_DATA: begin
                        tx  <= rd_byte;
                        ptr <= ptr + 7'd1;
                     end
                     default: tx <= '0;
                  endcase
               end
            end else if (sck_fall && bit_cnt != 3'd0) begin
               // No shift on the fall after a byte boundary: the freshly
               // loaded MSB must stay on miso for the next rising sck.
               tx <= {tx[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_multi_encoder_reader.sv
// Scoreboard bench: SPI master + encoder stimulus against a behavioural counter
// model; a monitor assembles miso bytes and compares with the expected queue.
module tb_spi_multi_encoder_reader;

   localparam int unsigned NUM_ENC     = 4;
   localparam int unsigned COUNT_W     = 16;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned NB          = COUNT_W / 8;
   localparam int unsigned CMOD        = 1 << COUNT_W;
   localparam int unsigned HALF        = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_ENC-1:0] encA = '0;
   logic [NUM_ENC-1:0] encB = '0;
   logic               cs_n = 1'b1;
   logic               sck = 1'b0;
   logic               mosi = 1'b0;
   logic               miso, miso_oe;
   logic [NUM_ENC-1:0] errFlags;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   int unsigned mcnt[NUM_ENC];
   bit          merr[NUM_ENC];
   int unsigned phase[NUM_ENC];
   int unsigned snap_cnt[NUM_ENC];
   bit          snap_err[NUM_ENC];

   always #5 clk = ~clk;

   spi_multi_encoder_reader #(
      .NUM_ENC(NUM_ENC),
      .COUNT_W(COUNT_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .encA(encA),
      .encB(encB),
      .cs_n(cs_n),
      .sck(sck),
      .mosi(mosi),
      .miso(miso),
      .miso_oe(miso_oe),
      .errFlags(errFlags)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [NUM_ENC-1:0] model_err_vec();
      logic [NUM_ENC-1:0] v;
      v = '0;
      for (int c = 0; c < NUM_ENC; c++) v[c] = merr[c];
      return v;
   endfunction

   function automatic logic [7:0] map_byte(input int unsigned addr);
      int unsigned ch, idx, e;
      if (addr < NUM_ENC * NB) begin
         ch  = addr / NB;
         idx = addr % NB;
         return 8'((snap_cnt[ch] >> (8 * (NB - 1 - idx))) % 256);
      end else if (addr == NUM_ENC * NB) begin
         e = 0;
         for (int c = 0; c < NUM_ENC; c++) if (snap_err[c]) e += (1 << c);
         return 8'(e);
      end
      return 8'h00;
   endfunction

   task automatic take_snapshot();
      for (int c = 0; c < NUM_ENC; c++) begin
         snap_cnt[c] = mcnt[c];
         snap_err[c] = merr[c];
      end
   endtask

   // Gray sequence 00 -> 01 -> 11 -> 10 indexed by position
   task automatic drive_pins(input int unsigned ch);
      case (phase[ch])
         0: begin encA[ch] = 1'b0; encB[ch] = 1'b0; end
         1: begin encA[ch] = 1'b0; encB[ch] = 1'b1; end
         2: begin encA[ch] = 1'b1; encB[ch] = 1'b1; end
         default: begin encA[ch] = 1'b1; encB[ch] = 1'b0; end
      endcase
   endtask

   task automatic step(input int unsigned ch, input bit fwd);
      phase[ch] = (phase[ch] + (fwd ? 1 : 3)) % 4;
      drive_pins(ch);
      mcnt[ch] = (mcnt[ch] + (fwd ? 1 : CMOD - 1)) % CMOD;
      wait_clk(4);
   endtask

   task automatic illegal(input int unsigned ch);
      phase[ch] = (phase[ch] + 2) % 4;
      drive_pins(ch);
      merr[ch] = 1'b1;
      wait_clk(4);
   endtask

   task automatic spi_bits(input logic [7:0] b, input int unsigned nbits);
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7-i];
         wait_clk(HALF);
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic begin_xfer();
      cs_n = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic end_xfer();
      wait_clk(HALF);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(2 * HALF);
   endtask

   task automatic spi_read(input int unsigned start, input int unsigned n);
      take_snapshot();
      exp_q.push_back(8'h00);
      for (int unsigned k = 1; k <= n; k++) exp_q.push_back(map_byte((start + k - 1) % 128));
      begin_xfer();
      spi_bits(8'(start), 8);
      for (int unsigned k = 0; k < n; k++) spi_bits(8'($urandom), 8);
      end_xfer();
   endtask

   task automatic spi_clear(input int unsigned ch, input int unsigned extra);
      for (int unsigned k = 0; k <= extra; k++) exp_q.push_back(8'h00);
      begin_xfer();
      spi_bits(8'h80 | 8'(ch), 8);
      for (int unsigned k = 0; k < extra; k++) spi_bits(8'($urandom), 8);
      end_xfer();
      if (ch < NUM_ENC) begin
         mcnt[ch] = 0;
         merr[ch] = 1'b0;
      end
   endtask

   // Monitor: assemble miso on each rising sck while selected; deselect discards.
   initial begin : monitor
      int         nb;
      logic [7:0] sh;
      logic [7:0] e;
      nb = 0;
      sh = '0;
      forever begin
         @(posedge sck or posedge cs_n);
         if (cs_n) begin
            nb = 0;
         end else begin
            sh = {sh[6:0], miso};
            nb++;
            if (nb == 8) begin
               nb = 0;
               if (exp_q.size() == 0) begin
                  check("spi_byte_unexpected", sh, 8'h00);
                  if (sh == 8'h00) begin
                     errors++;
                     $display("FAIL spi_byte_unexpected: got %0h expected none", sh);
                  end
               end else begin
                  e = exp_q.pop_front();
                  check("spi_byte", sh, e);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0]  b;
      int unsigned op, ch, n;
      for (int c = 0; c < NUM_ENC; c++) begin
         mcnt[c]  = 0;
         merr[c]  = 1'b0;
         phase[c] = 0;
      end

      wait_clk(3);
      check("reset_miso", miso, 1'b0);
      check("reset_miso_oe", miso_oe, 1'b0);
      check("reset_err", errFlags, '0);
      rst_n = 1'b1;
      wait_clk(4);
      check("post_reset_err", errFlags, '0);

      // forward on ch0, reverse on ch1, full map read
      for (int i = 0; i < 5; i++) step(0, 1'b1);
      for (int i = 0; i < 3; i++) step(1, 1'b0);
      spi_read(0, 9);

      // wrap in both directions on ch2
      step(2, 1'b0);
      spi_read(4, 2);
      step(2, 1'b1);
      spi_read(4, 2);
      step(2, 1'b0);
      spi_read(4, 2);
      check("wrap_err_unchanged", errFlags, model_err_vec());

      // illegal double change on ch3, then clear it
      illegal(3);
      check("illegal_err", errFlags, model_err_vec());
      spi_read(8, 1);
      spi_clear(3, 1);
      check("clear_err", errFlags, model_err_vec());
      spi_read(6, 3);

      // coherent snapshot while ch0 keeps stepping
      fork
         spi_read(0, 2);
         begin
            wait_clk(2 * HALF);
            for (int i = 0; i < 6; i++) step(0, 1'b1);
         end
      join
      spi_read(0, 2);

      // aborted clear command
      begin_xfer();
      spi_bits(8'h80, 4);
      check("oe_selected", miso_oe, 1'b1);
      cs_n = 1'b1;
      wait_clk(SYNC_STAGES + 1);
      check("oe_after_abort", miso_oe, 1'b0);
      check("miso_after_abort", miso, 1'b0);
      wait_clk(2 * HALF);
      spi_read(0, 2);

      // address wrap 127 -> 0
      spi_read(127, 2);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(0, 9);
         ch = $urandom_range(0, NUM_ENC - 1);
         if (op <= 4) begin
            n = $urandom_range(1, 6);
            b = 8'($urandom_range(0, 1));
            for (int unsigned i = 0; i < n; i++) step(ch, b[0]);
         end else if (op == 5) begin
            if ($urandom_range(0, 2) == 0) illegal(ch);
            else step(ch, 1'b1);
         end else if (op <= 8) begin
            n = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 9) : $urandom_range(0, 127);
            spi_read(n, $urandom_range(1, 4));
         end else begin
            spi_clear($urandom_range(0, NUM_ENC + 1), $urandom_range(0, 2));
         end
         check("rand_err", errFlags, model_err_vec());
      end

      // reset in the middle of a data byte
      for (int c = 0; c < NUM_ENC; c++) while (phase[c] != 0) step(c, 1'b1);
      for (int i = 0; i < 4; i++) step(0, 1'b1);
      take_snapshot();
      b = map_byte(1);
      exp_q.push_back(8'h00);
      begin_xfer();
      spi_bits(8'h01, 8);
      spi_bits(8'h00, 3);
      wait_clk(HALF);
      check("mid_byte_miso", miso, b[4]);
      rst_n = 1'b0;
      #1;
      check("rst_mid_miso", miso, 1'b0);
      check("rst_mid_oe", miso_oe, 1'b0);
      check("rst_mid_err", errFlags, '0);
      for (int c = 0; c < NUM_ENC; c++) begin
         mcnt[c] = 0;
         merr[c] = 1'b0;
      end
      wait_clk(2);
      cs_n = 1'b1;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(4);
      spi_read(0, 9);

      wait_clk(4);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
